mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multicycle control sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. In each state it drives the datapath enables PCWr, IRWr, RFWr and DMWr, the operand and next-PC selects, the ALU op and the extender op. It sits beside the register file, ALU, extender, next-PC unit and data memory, and takes op/funct from the instruction register and zero from the ALU.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- op  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  data memory accepts/returns this cycle.
- PCWr  out  1  PC write enable.
- IRWr  out  1  IR write enable.
- RFWr  out  1  register file write enable.
- DMWr  out  1  data memory write enable.
- NPCOp  out  2  next-PC select: 0 PC+4, 1 branch (PC+4+ext<<2), 2 jump.
- ALUSrcB  out  1  ALU B operand: 0 RD2, 1 extended immediate.
- ALUOp  out  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT.
- ExtOp  out  2  extender op: 0 zero-extend, 1 sign-extend, 2 imm<<16.
- RegDst  out  1  write register: 0 rt, 1 rd.
- Mem2R  out  1  write data: 0 ALU result, 1 DM output.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- state  out  4  current FSM state, for debug.
- instr_cnt  out  32  count of retired instructions.

## Operation
- Supported instructions:
  - R-type (op 000000) with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010.
  - I-type: addi 001000, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101.
  - Jump: j 000010.
- States: FETCH, DECODE, EXE, ALUWB, MADR, MRD, MWB, MWR, BR, JMP.
- FETCH: IRWr=1, PCWr=1, NPCOp=0. Next state DECODE.
- DECODE: no enables asserted. Next state by op:
  - R-type, addi, ori, lui -> EXE.
  - lw, sw -> MADR.
  - beq, bne -> BR.
  - j -> JMP.
  - Anything else, including an R-type with an unsupported funct -> FETCH, with illegal=1 for this cycle. The instruction is not counted.
- EXE: ALUSrcB=0 for R-type and 1 for I-type. ALUOp comes from funct (R-type), ADD (addi), OR (ori) or OR with $zero base (lui). ExtOp is 1 for addi, 0 for ori and 2 for lui. Next state ALUWB.
- ALUWB: RFWr=1, Mem2R=0, RegDst=1 for R-type and 0 otherwise. ALU and extender controls are held at their EXE values. Next state FETCH.
- MADR: ALUSrcB=1, ExtOp=1, ALUOp=ADD. Next state MRD for lw, MWR for sw.
- MRD: holds the address controls. Stays in MRD while mem_ready=0, then moves to MWB.
- MWB: RFWr=1, Mem2R=1, RegDst=0, address controls held. Next state FETCH.
- MWR: DMWr=1 and address controls held every cycle in this state. The write commits on the cycle mem_ready=1, and the FSM then moves to FETCH. DMWr stays high through wait cycles.
- BR: ALUSrcB=0, ALUOp=SUB, ExtOp=1, NPCOp=1. PCWr=zero for beq and PCWr=~zero for bne. Next state FETCH.
- JMP: PCWr=1, NPCOp=2. Next state FETCH.
- Outputs not listed for a state are 0.
- instr_cnt increments by 1 on each transition into FETCH from ALUWB, MWB, MWR (on commit), BR or JMP. It wraps from 0xFFFFFFFF to 0.
- op and funct must stay stable from DECODE until the instruction finishes. IR is only written in FETCH, so this holds.

## Timing
- Cycles per instruction, with mem_ready tied to 1:
  - j, beq, bne: 3.
  - R-type, I-type ALU: 4.
  - sw: 4.
  - lw: 5.
  - Each mem_ready=0 cycle in MRD or MWR adds one cycle.
- Illegal instruction: 2 cycles (FETCH, DECODE).
- Outputs are combinational from the state register and op/funct/zero, with no extra latency. State and instr_cnt are registered.
- Reset: a sampled rst=0 in any state, including mid-wait in MRD or MWR, sets state to FETCH and instr_cnt to 0 on the next edge.
  - While rst=0, PCWr, IRWr, RFWr, DMWr and illegal are forced to 0.
  - The first edge with rst=1 executes FETCH.
- mem_ready is ignored outside MRD and MWR.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit, FETCH=0);
  - opcode and funct constants;
  - the ALUOp, NPCOp and ExtOp encodings.
- Sub-module mc_decode is a purely combinational block. It maps op/funct to an instruction class (RTYPE, ALUI, LOAD, STORE, BRANCH, JUMP, ILLEGAL), an ALUOp, an ExtOp and an is_bne flag. The FSM in mc_ctrl consumes these.

## Test plan
- Reset held 3 cycles with DMWr/RFWr stimulus, then released:
  - all enables are 0 during reset;
  - state=FETCH and instr_cnt=0 after release;
  - IRWr=1 and PCWr=1 on the first cycle after release.
- addu (funct 100001): state sequence FETCH, DECODE, EXE, ALUWB. ALUOp=0, RegDst=1, RFWr=1 only in ALUWB. instr_cnt 0->1.
- lw with mem_ready=0 for 2 cycles in MRD: 7 cycles total. MWB has RFWr=1, Mem2R=1, RegDst=0, and RFWr is never asserted before MWB.
- sw with mem_ready=0 for 1 cycle: DMWr=1 for 2 consecutive cycles in MWR, then FETCH. instr_cnt increments once.
- beq with zero=1 gives PCWr=1 and NPCOp=1 in BR. bne with zero=1 gives PCWr=0. Both take 3 cycles.
- Other instructions:
  - op 111111: illegal=1 in DECODE, return to FETCH, instr_cnt unchanged.
  - rst=0 asserted mid-MWR: DMWr drops to 0 and the FSM restarts at FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : Shared types and encodings for the multicycle MIPS control
//                sequencer: FSM state enum, instruction classes, opcode and
//                funct constants, and the ALU / next-PC / extender encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // Sequencer states; FETCH is the reset state and must encode as zero.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXE    = 4'd2,
        ALUWB  = 4'd3,
        MADR   = 4'd4,
        MRD    = 4'd5,
        MWB    = 4'd6,
        MWR    = 4'd7,
        BR     = 4'd8,
        JMP    = 4'd9
    } state_t;

    // Instruction classes produced by the decoder.
    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_ALUI    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUBU = 6'b100011;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_SLT  = 6'b101010;

    // ALUOp encoding
    localparam logic [2:0] c_ALU_ADD = 3'd0;
    localparam logic [2:0] c_ALU_SUB = 3'd1;
    localparam logic [2:0] c_ALU_AND = 3'd2;
    localparam logic [2:0] c_ALU_OR  = 3'd3;
    localparam logic [2:0] c_ALU_SLT = 3'd4;

    // NPCOp encoding
    localparam logic [1:0] c_NPC_PLUS4  = 2'd0;
    localparam logic [1:0] c_NPC_BRANCH = 2'd1;
    localparam logic [1:0] c_NPC_JUMP   = 2'd2;

    // ExtOp encoding
    localparam logic [1:0] c_EXT_ZERO = 2'd0;
    localparam logic [1:0] c_EXT_SIGN = 2'd1;
    localparam logic [1:0] c_EXT_LUI  = 2'd2;

endpackage : mc_ctrl_pkg
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mc_decode
//  Description : Purely combinational instruction decoder. Classifies op/funct
//                and supplies the ALU and extender operations the instruction
//                needs, plus a flag distinguishing bne from beq.
//  Ports       : i_op[5:0]         opcode IR[31:26]
//                i_funct[5:0]      funct IR[5:0]
//                o_instrClass      instruction class
//                o_aluOp[2:0]      ALU operation for the instruction
//                o_extOp[1:0]      extender operation for the instruction
//                o_isBne           branch sense is "not equal"
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_funct,
    output instr_class_t o_instrClass,
    output logic [2:0]   o_aluOp,
    output logic [1:0]   o_extOp,
    output logic         o_isBne
);

    always_comb begin
        o_instrClass = CLS_ILLEGAL;
        o_aluOp      = c_ALU_ADD;
        o_extOp      = c_EXT_ZERO;
        o_isBne      = 1'b0;
        case (i_op)
            c_OP_RTYPE: begin
                o_instrClass = CLS_RTYPE;
                case (i_funct)
                    c_FN_ADDU: o_aluOp = c_ALU_ADD;
                    c_FN_SUBU: o_aluOp = c_ALU_SUB;
                    c_FN_AND:  o_aluOp = c_ALU_AND;
                    c_FN_OR:   o_aluOp = c_ALU_OR;
                    c_FN_SLT:  o_aluOp = c_ALU_SLT;
                    default:   o_instrClass = CLS_ILLEGAL;
                endcase
            end
            c_OP_ADDI: begin
                o_instrClass = CLS_ALUI;
                o_aluOp      = c_ALU_ADD;
                o_extOp      = c_EXT_SIGN;
            end
            c_OP_ORI: begin
                o_instrClass = CLS_ALUI;
                o_aluOp      = c_ALU_OR;
                o_extOp      = c_EXT_ZERO;
            end
            c_OP_LUI: begin
                // lui is rs($zero) OR (imm<<16); the base register field is 0.
                o_instrClass = CLS_ALUI;
                o_aluOp      = c_ALU_OR;
                o_extOp      = c_EXT_LUI;
            end
            c_OP_LW: begin
                o_instrClass = CLS_LOAD;
                o_aluOp      = c_ALU_ADD;
                o_extOp      = c_EXT_SIGN;
            end
            c_OP_SW: begin
                o_instrClass = CLS_STORE;
                o_aluOp      = c_ALU_ADD;
                o_extOp      = c_EXT_SIGN;
            end
            c_OP_BEQ: begin
                o_instrClass = CLS_BRANCH;
                o_aluOp      = c_ALU_SUB;
                o_extOp      = c_EXT_SIGN;
            end
            c_OP_BNE: begin
                o_instrClass = CLS_BRANCH;
                o_aluOp      = c_ALU_SUB;
                o_extOp      = c_EXT_SIGN;
                o_isBne      = 1'b1;
            end
            c_OP_J: begin
                o_instrClass = CLS_JUMP;
            end
            default: ;
        endcase
    end

endmodule : mc_decode
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl
//  Description : Multicycle Moore control sequencer for the MIPS datapath.
//                Steps each instruction through fetch, decode, execute, memory
//                and write-back, driving datapath enables and selects.
//  Ports       : clk               system clock, rising edge
//                rst               synchronous reset, active low
//                op[5:0], funct[5:0] instruction fields from IR
//                zero              ALU zero flag
//                mem_ready         data memory handshake (MRD/MWR only)
//                PCWr, IRWr, RFWr, DMWr  datapath write enables
//                NPCOp[1:0], ALUSrcB, ALUOp[2:0], ExtOp[1:0], RegDst, Mem2R
//                                  datapath selects
//                illegal           one-cycle pulse on unsupported instruction
//                state[3:0]        current FSM state (debug)
//                instr_cnt[31:0]   retired instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic        IRWr,
    output logic        RFWr,
    output logic        DMWr,
    output logic [1:0]  NPCOp,
    output logic        ALUSrcB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  ExtOp,
    output logic        RegDst,
    output logic        Mem2R,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] instr_cnt
);

    state_t       r_state;
    logic [31:0]  r_instrCnt;

    instr_class_t w_class;
    logic [2:0]   w_aluOp;
    logic [1:0]   w_extOp;
    logic         w_isBne;

    logic         w_pcWr;
    logic         w_irWr;
    logic         w_rfWr;
    logic         w_dmWr;
    logic         w_illegal;

    mc_decode u_decode (
        .i_op         (op),
        .i_funct      (funct),
        .o_instrClass (w_class),
        .o_aluOp      (w_aluOp),
        .o_extOp      (w_extOp),
        .o_isBne      (w_isBne)
    );

    // State register and retire counter. Every path back to FETCH except
    // the illegal-instruction exit from DECODE retires one instruction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= FETCH;
            r_instrCnt <= '0;
        end else begin
            case (r_state)
                FETCH:  r_state <= DECODE;
                DECODE: begin
                    case (w_class)
                        CLS_RTYPE, CLS_ALUI:  r_state <= EXE;
                        CLS_LOAD, CLS_STORE:  r_state <= MADR;
                        CLS_BRANCH:           r_state <= BR;
                        CLS_JUMP:             r_state <= JMP;
                        default:              r_state <= FETCH;
                    endcase
                end
                EXE:    r_state <= ALUWB;
                ALUWB: begin
                    r_state    <= FETCH;
                    r_instrCnt <= r_instrCnt + 32'd1;
                end
                MADR:   r_state <= (w_class == CLS_STORE) ? MWR : MRD;
                MRD: begin
                    if (mem_ready) r_state <= MWB;
                end
                MWB: begin
                    r_state    <= FETCH;
                    r_instrCnt <= r_instrCnt + 32'd1;
                end
                MWR: begin
                    // The store commits on the ready cycle; until then keep waiting.
                    if (mem_ready) begin
                        r_state    <= FETCH;
                        r_instrCnt <= r_instrCnt + 32'd1;
                    end
                end
                BR, JMP: begin
                    r_state    <= FETCH;
                    r_instrCnt <= r_instrCnt + 32'd1;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    // Moore outputs decoded from the current state (plus op/funct/zero).
    always_comb begin
        w_pcWr    = 1'b0;
        w_irWr    = 1'b0;
        w_rfWr    = 1'b0;
        w_dmWr    = 1'b0;
        w_illegal = 1'b0;
        NPCOp     = c_NPC_PLUS4;
        ALUSrcB   = 1'b0;
        ALUOp     = c_ALU_ADD;
        ExtOp     = c_EXT_ZERO;
        RegDst    = 1'b0;
        Mem2R     = 1'b0;
        case (r_state)
            FETCH: begin
                w_irWr = 1'b1;
                w_pcWr = 1'b1;
            end
            DECODE: begin
                w_illegal = (w_class == CLS_ILLEGAL);
            end
            EXE, ALUWB: begin
                // ALUWB keeps the EXE operand controls so the result is stable.
                ALUSrcB = (w_class != CLS_RTYPE);
                ALUOp   = w_aluOp;
                ExtOp   = w_extOp;
                if (r_state == ALUWB) begin
                    w_rfWr = 1'b1;
                    RegDst = (w_class == CLS_RTYPE);
                end
            end
            MADR, MRD, MWB, MWR: begin
                // Address computation base+signext(imm) held through the access.
                ALUSrcB = 1'b1;
                ExtOp   = c_EXT_SIGN;
                ALUOp   = c_ALU_ADD;
                if (r_state == MWB) begin
                    w_rfWr = 1'b1;
                    Mem2R  = 1'b1;
                end
                if (r_state == MWR) begin
                    w_dmWr = 1'b1;
                end
            end
            BR: begin
                ALUOp  = c_ALU_SUB;
                ExtOp  = c_EXT_SIGN;
                NPCOp  = c_NPC_BRANCH;
                w_pcWr = w_isBne ? ~zero : zero;
            end
            JMP: begin
                w_pcWr = 1'b1;
                NPCOp  = c_NPC_JUMP;
            end
            default: ;
        endcase
    end

    // Enables are suppressed combinationally while reset is asserted so no
    // datapath state changes before the FSM is back in FETCH.
    assign PCWr      = rst & w_pcWr;
    assign IRWr      = rst & w_irWr;
    assign RFWr      = rst & w_rfWr;
    assign DMWr      = rst & w_dmWr;
    assign illegal   = rst & w_illegal;
    assign state     = r_state;
    assign instr_cnt = r_instrCnt;

endmodule : mc_ctrl
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mc_ctrl
//  Description : Self-checking bench for mc_ctrl: reset behaviour, a directed
//                vector table, multi-cycle corner sequences and randomized
//                instructions checked against an instruction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        PCWr, IRWr, RFWr, DMWr, ALUSrcB, RegDst, Mem2R, illegal;
    logic [1:0]  NPCOp, ExtOp;
    logic [2:0]  ALUOp;
    logic [3:0]  state;
    logic [31:0] instr_cnt;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr),
        .DMWr(DMWr), .NPCOp(NPCOp), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ExtOp(ExtOp), .RegDst(RegDst), .Mem2R(Mem2R), .illegal(illegal),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- per-instruction observation ----------------
    int         oCycles, oIr, oPc, oRf, oDm, oIll;
    logic       oWbRegDst, oWbMem2R, oWbSrcB;
    logic [2:0] oWbAlu;
    logic [1:0] oWbExt, oNpc;
    logic [3:0] obsState [0:39];
    logic       obsIr [0:39];
    logic       obsPc [0:39];
    logic       obsRf [0:39];
    logic       obsDm [0:39];

    // Runs one instruction starting at posedge+1 with the DUT in FETCH.
    // lw/sw reach their memory state on cycle 4; mem_ready is held low for
    // 'waits' cycles there and randomised on every cycle where it is ignored.
    task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input logic z, input int waits);
        int memStart;
        bit done;
        memStart = (o == 6'b100011 || o == 6'b101011) ? 4 : 0;
        op = o; funct = f; zero = z;
        oCycles = 0; oIr = 0; oPc = 0; oRf = 0; oDm = 0; oIll = 0;
        oWbRegDst = 1'bx; oWbMem2R = 1'bx; oWbSrcB = 1'bx; oWbAlu = 3'bx; oWbExt = 2'bx; oNpc = 2'bx;
        done = 1'b0;
        for (int k = 1; k <= 40 && !done; k++) begin
            if (memStart != 0 && k >= memStart) mem_ready = (k >= memStart + waits);
            else mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            obsState[k-1] = state; obsIr[k-1] = IRWr; obsPc[k-1] = PCWr;
            obsRf[k-1] = RFWr; obsDm[k-1] = DMWr;
            if (IRWr) oIr++;
            if (PCWr) oPc++;
            if (DMWr) oDm++;
            if (illegal) oIll++;
            if (RFWr) begin
                oRf++;
                oWbRegDst = RegDst; oWbMem2R = Mem2R; oWbSrcB = ALUSrcB;
                oWbAlu = ALUOp; oWbExt = ExtOp;
            end
            if (PCWr && !IRWr) oNpc = NPCOp;
            @(posedge clk); #1;
            oCycles = k;
            if (state == 4'd0) done = 1'b1;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int         waits;
        int         cyc, pc, rf, dm, ill, inc;
        logic [2:0] alu;
    } vec_t;
    vec_t vecs [12];

    // ---------------- reference model: legal instruction set ----------------
    localparam int c_K_R = 0, c_K_ALUI = 1, c_K_LOAD = 2, c_K_STORE = 3,
                   c_K_BEQ = 4, c_K_BNE = 5, c_K_J = 6;
    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        int         kind;
        logic [2:0] alu;
        logic [1:0] ext;
    } legal_t;
    legal_t legal [13];

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        for (int i = 0; i < 13; i++)
            if (legal[i].op == o && (o != 6'd0 || legal[i].funct == f)) return i;
        return -1;
    endfunction

    int expCnt = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx, kind, w, eCyc, ePc, eRf, eDm;
        logic z;
        logic [5:0] ro, rf;

        legal[0]  = '{6'b000000, 6'b100001, c_K_R,     3'd0, 2'd0};
        legal[1]  = '{6'b000000, 6'b100011, c_K_R,     3'd1, 2'd0};
        legal[2]  = '{6'b000000, 6'b100100, c_K_R,     3'd2, 2'd0};
        legal[3]  = '{6'b000000, 6'b100101, c_K_R,     3'd3, 2'd0};
        legal[4]  = '{6'b000000, 6'b101010, c_K_R,     3'd4, 2'd0};
        legal[5]  = '{6'b001000, 6'b000000, c_K_ALUI,  3'd0, 2'd1};
        legal[6]  = '{6'b001101, 6'b000000, c_K_ALUI,  3'd3, 2'd0};
        legal[7]  = '{6'b001111, 6'b000000, c_K_ALUI,  3'd3, 2'd2};
        legal[8]  = '{6'b100011, 6'b000000, c_K_LOAD,  3'd0, 2'd1};
        legal[9]  = '{6'b101011, 6'b000000, c_K_STORE, 3'd0, 2'd1};
        legal[10] = '{6'b000100, 6'b000000, c_K_BEQ,   3'd1, 2'd1};
        legal[11] = '{6'b000101, 6'b000000, c_K_BNE,   3'd1, 2'd1};
        legal[12] = '{6'b000010, 6'b000000, c_K_J,     3'd0, 2'd0};

        //          op         funct      z     w  cyc pc rf dm ill inc alu
        vecs[0]  = '{6'b000000, 6'b100001, 1'b0, 0, 4, 1, 1, 0, 0, 1, 3'd0};
        vecs[1]  = '{6'b000000, 6'b100011, 1'b0, 0, 4, 1, 1, 0, 0, 1, 3'd1};
        vecs[2]  = '{6'b000000, 6'b101010, 1'b1, 0, 4, 1, 1, 0, 0, 1, 3'd4};
        vecs[3]  = '{6'b001000, 6'b010101, 1'b0, 0, 4, 1, 1, 0, 0, 1, 3'd0};
        vecs[4]  = '{6'b001111, 6'b000000, 1'b0, 0, 4, 1, 1, 0, 0, 1, 3'd3};
        vecs[5]  = '{6'b100011, 6'b000000, 1'b0, 2, 7, 1, 1, 0, 0, 1, 3'd0};
        vecs[6]  = '{6'b101011, 6'b000000, 1'b0, 1, 5, 1, 0, 2, 0, 1, 3'd0};
        vecs[7]  = '{6'b000100, 6'b000000, 1'b1, 0, 3, 2, 0, 0, 0, 1, 3'd0};
        vecs[8]  = '{6'b000101, 6'b000000, 1'b1, 0, 3, 1, 0, 0, 0, 1, 3'd0};
        vecs[9]  = '{6'b000010, 6'b000000, 1'b0, 0, 3, 2, 0, 0, 0, 1, 3'd0};
        vecs[10] = '{6'b111111, 6'b000000, 1'b0, 0, 2, 1, 0, 0, 1, 0, 3'd0};
        vecs[11] = '{6'b000000, 6'b000000, 1'b0, 0, 2, 1, 0, 0, 1, 0, 3'd0};

        // ---- reset held 3 cycles with store/wait stimulus ----
        rst = 1'b0; op = 6'b101011; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_enables", 32'({PCWr, IRWr, RFWr, DMWr, illegal}), 32'd0);
            @(posedge clk); #1;
        end
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_cnt", instr_cnt, 32'd0);
        rst = 1'b1;

        // ---- addu: first instruction after release ----
        runInstr(6'b000000, 6'b100001, 1'b0, 0);
        expCnt = 1;
        chk("addu_first_irwr", 32'(obsIr[0]), 32'd1);
        chk("addu_first_pcwr", 32'(obsPc[0]), 32'd1);
        chk("addu_states", 32'({obsState[0], obsState[1], obsState[2], obsState[3]}), 32'h0123);
        chk("addu_rfwr_seq", 32'({obsRf[0], obsRf[1], obsRf[2], obsRf[3]}), 32'b0001);
        chk("addu_aluop", 32'(oWbAlu), 32'd0);
        chk("addu_regdst", 32'(oWbRegDst), 32'd1);
        chk("addu_cnt", instr_cnt, 32'd1);

        // ---- directed table ----
        for (int i = 0; i < 12; i++) begin
            runInstr(vecs[i].op, vecs[i].funct, vecs[i].z, vecs[i].waits);
            expCnt += vecs[i].inc;
            chk($sformatf("vec%0d_cycles", i), 32'(oCycles), 32'(vecs[i].cyc));
            chk($sformatf("vec%0d_pcwr", i), 32'(oPc), 32'(vecs[i].pc));
            chk($sformatf("vec%0d_rfwr", i), 32'(oRf), 32'(vecs[i].rf));
            chk($sformatf("vec%0d_dmwr", i), 32'(oDm), 32'(vecs[i].dm));
            chk($sformatf("vec%0d_illegal", i), 32'(oIll), 32'(vecs[i].ill));
            chk($sformatf("vec%0d_cnt", i), instr_cnt, 32'(expCnt));
            if (vecs[i].rf != 0) chk($sformatf("vec%0d_aluop", i), 32'(oWbAlu), 32'(vecs[i].alu));
        end

        // ---- lw with two wait cycles: write-back only in MWB (cycle 7) ----
        runInstr(6'b100011, 6'b000000, 1'b0, 2);
        expCnt++;
        chk("lw_rfwr_seq", 32'({obsRf[0], obsRf[1], obsRf[2], obsRf[3], obsRf[4], obsRf[5], obsRf[6]}), 32'b0000001);
        chk("lw_mwb_state", 32'(obsState[6]), 32'd6);
        chk("lw_mem2r", 32'(oWbMem2R), 32'd1);
        chk("lw_regdst", 32'(oWbRegDst), 32'd0);

        // ---- sw with one wait cycle: DMWr on two consecutive cycles ----
        runInstr(6'b101011, 6'b000000, 1'b0, 1);
        expCnt++;
        chk("sw_dmwr_seq", 32'({obsDm[2], obsDm[3], obsDm[4]}), 32'b011);
        chk("sw_cnt", instr_cnt, 32'(expCnt));

        // ---- randomized instructions against the instruction-level model ----
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                idx = $urandom_range(0, 12);
                ro = legal[idx].op;
                rf = (ro == 6'd0) ? legal[idx].funct : 6'($urandom);
            end else begin
                ro = 6'($urandom);
                rf = 6'($urandom);
            end
            z = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 3);
            idx = classify(ro, rf);
            kind = (idx < 0) ? -1 : legal[idx].kind;
            case (kind)
                c_K_R, c_K_ALUI: eCyc = 4;
                c_K_LOAD:        eCyc = 5 + w;
                c_K_STORE:       eCyc = 4 + w;
                c_K_BEQ, c_K_BNE, c_K_J: eCyc = 3;
                default:         eCyc = 2;
            endcase
            ePc = 1 + ((kind == c_K_J) ? 1 : (kind == c_K_BEQ) ? int'(z) : (kind == c_K_BNE) ? int'(!z) : 0);
            eRf = (kind == c_K_R || kind == c_K_ALUI || kind == c_K_LOAD) ? 1 : 0;
            eDm = (kind == c_K_STORE) ? 1 + w : 0;
            if (idx >= 0) expCnt++;

            runInstr(ro, rf, z, w);
            chk($sformatf("rnd%0d_cycles op=%b fn=%b", n, ro, rf), 32'(oCycles), 32'(eCyc));
            chk($sformatf("rnd%0d_irwr", n), 32'(oIr), 32'd1);
            chk($sformatf("rnd%0d_pcwr", n), 32'(oPc), 32'(ePc));
            chk($sformatf("rnd%0d_rfwr", n), 32'(oRf), 32'(eRf));
            chk($sformatf("rnd%0d_dmwr", n), 32'(oDm), 32'(eDm));
            chk($sformatf("rnd%0d_illegal", n), 32'(oIll), (idx < 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d_cnt", n), instr_cnt, 32'(expCnt));
            if (eRf != 0) begin
                chk($sformatf("rnd%0d_aluop", n), 32'(oWbAlu), 32'(legal[idx].alu));
                chk($sformatf("rnd%0d_extop", n), 32'(oWbExt), 32'(legal[idx].ext));
                chk($sformatf("rnd%0d_regdst", n), 32'(oWbRegDst), (kind == c_K_R) ? 32'd1 : 32'd0);
                chk($sformatf("rnd%0d_mem2r", n), 32'(oWbMem2R), (kind == c_K_LOAD) ? 32'd1 : 32'd0);
                chk($sformatf("rnd%0d_srcb", n), 32'(oWbSrcB), (kind == c_K_R) ? 32'd0 : 32'd1);
            end
            if (ePc > 1) chk($sformatf("rnd%0d_npcop", n), 32'(oNpc), (kind == c_K_J) ? 32'd2 : 32'd1);
        end

        // ---- reset asserted while waiting in MWR ----
        op = 6'b101011; funct = 6'd0; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("mwr_dmwr_before_rst", 32'(DMWr), 32'd1);
        rst = 1'b0;
        #1;
        chk("mwr_dmwr_in_rst", 32'(DMWr), 32'd0);
        @(posedge clk); #1;
        chk("mwr_rst_state", 32'(state), 32'd0);
        chk("mwr_rst_cnt", instr_cnt, 32'd0);
        rst = 1'b1;
        runInstr(6'b000000, 6'b100101, 1'b0, 0);
        chk("post_rst_cycles", 32'(oCycles), 32'd4);
        chk("post_rst_cnt", instr_cnt, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mc_ctrl
`default_nettype wire
